// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
// Holds state encodings, the control-bit bundle and the wait counter sizing helper.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_NUM = 5;

  typedef enum logic [1:0] {
    HZ_RUN       = 2'd0,
    HZ_LU_BUBBLE = 2'd1,
    HZ_MEM_WAIT  = 2'd2
  } hz_state_e;

  // Bit order of any packed stall/flush bus, MSB first.
  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic stall_idex;
    logic stall_exmem;
    logic flush_ifid;
    logic flush_idex;
    logic flush_memwb;
  } hz_ctl_t;

  function automatic int wait_cnt_width(input int timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_lu_detect.sv
// Load-use comparator: the instruction in ID reads a register that the load in EX
// has not produced yet. Register 0 is hardwired and never creates a hazard.
module hazard_load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_re,
  input  logic             id_rs2_re,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             lu_hit
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_rs1_re && (id_rs1 == ex_rd);
  assign rs2_match = id_rs2_re && (id_rs2 == ex_rd);
  assign lu_hit    = ex_mem_read && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//
//   state        | meaning
//   HZ_RUN       | pipe flowing; single-cycle load-use bubble or branch squash as needed
//   HZ_LU_BUBBLE | extra load-use bubbles while lu_cnt counts down to 1
//   HZ_MEM_WAIT  | pipe frozen until mem_ready or the wait limit; pending redirect held
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W       = REG_NUM,
  parameter int LU_BUBBLES  = 1,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_re,
  input  logic             id_rs2_re,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_exmem,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_memwb,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int         WAIT_W    = wait_cnt_width(MEM_TIMEOUT);
  localparam logic [2:0] LU_RELOAD = 3'(LU_BUBBLES - 1);

  hz_state_e   state;
  logic [2:0]  lu_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic        redirect_pend;
  logic        lu_hit;
  logic        memw;
  logic        wait_expired;
  logic        release_now;
  hz_ctl_t     ctl;

  hazard_load_use_detect #(.REG_W(REG_W)) u_lu_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_re   (id_rs1_re),
    .id_rs2_re   (id_rs2_re),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .lu_hit      (lu_hit)
  );

  assign memw         = mem_req && !mem_ready;
  assign wait_expired = (MEM_TIMEOUT != 0) && (wait_cnt >= WAIT_W'(MEM_TIMEOUT));
  assign release_now  = (state == HZ_MEM_WAIT) && (mem_ready || wait_expired);

  always_comb begin
    ctl = '0;
    if (rst) begin
      ctl.flush_ifid  = 1'b1;
      ctl.flush_idex  = 1'b1;
      ctl.flush_memwb = 1'b1;
    end else begin
      case (state)
        HZ_MEM_WAIT: begin
          if (release_now) begin
            ctl.flush_ifid = redirect_pend || ex_branch_taken;
            ctl.flush_idex = redirect_pend || ex_branch_taken;
          end else begin
            ctl.stall_pc    = 1'b1;
            ctl.stall_ifid  = 1'b1;
            ctl.stall_idex  = 1'b1;
            ctl.stall_exmem = 1'b1;
            ctl.flush_memwb = 1'b1;
          end
        end
        default: begin
          if (memw) begin
            ctl.stall_pc    = 1'b1;
            ctl.stall_ifid  = 1'b1;
            ctl.stall_idex  = 1'b1;
            ctl.stall_exmem = 1'b1;
            ctl.flush_memwb = 1'b1;
          end else if (ex_branch_taken) begin
            ctl.flush_ifid = 1'b1;
            ctl.flush_idex = 1'b1;
          end else if (lu_hit || (state == HZ_LU_BUBBLE)) begin
            ctl.stall_pc   = 1'b1;
            ctl.stall_ifid = 1'b1;
            ctl.flush_idex = 1'b1;
          end
        end
      endcase
    end
  end

  assign stall_pc    = ctl.stall_pc;
  assign stall_ifid  = ctl.stall_ifid;
  assign stall_idex  = ctl.stall_idex;
  assign stall_exmem = ctl.stall_exmem;
  assign flush_ifid  = ctl.flush_ifid;
  assign flush_idex  = ctl.flush_idex;
  assign flush_memwb = ctl.flush_memwb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HZ_RUN;
      lu_cnt        <= '0;
      wait_cnt      <= '0;
      redirect_pend <= 1'b0;
      mem_timeout   <= 1'b0;
      stall_cycles  <= '0;
    end else begin
      if (ctl.stall_pc && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;

      case (state)
        HZ_RUN: begin
          if (memw) begin
            wait_cnt      <= WAIT_W'(1);
            redirect_pend <= ex_branch_taken;
            state         <= HZ_MEM_WAIT;
          end else if (!ex_branch_taken && lu_hit && (LU_BUBBLES > 1)) begin
            lu_cnt <= LU_RELOAD;
            state  <= HZ_LU_BUBBLE;
          end
        end
        HZ_LU_BUBBLE: begin
          // A memory wait swallows the remaining bubbles: it already covers the load latency.
          if (memw) begin
            wait_cnt      <= WAIT_W'(1);
            redirect_pend <= ex_branch_taken;
            state         <= HZ_MEM_WAIT;
          end else if (ex_branch_taken) begin
            state <= HZ_RUN;
          end else begin
            lu_cnt <= lu_cnt - 1'b1;
            if (lu_cnt == 3'd1)
              state <= HZ_RUN;
          end
        end
        HZ_MEM_WAIT: begin
          if (release_now) begin
            redirect_pend <= 1'b0;
            state         <= HZ_RUN;
            if (!mem_ready)
              mem_timeout <= 1'b1;
          end else begin
            if (wait_cnt != {WAIT_W{1'b1}})
              wait_cnt <= wait_cnt + 1'b1;
            redirect_pend <= redirect_pend || ex_branch_taken;
          end
        end
        default: state <= HZ_RUN;
      endcase
    end
  end

endmodule
